bcd_counter_scan_display: RTL and testbench
===========================================

Name: bcd_counter_scan_display

Overview:
- Parametrised decimal up/down counter with a built-in multiplexed 7-segment driver, generalising the fixed 4-digit counter/display top.
- Digit count, count rate, scan rate and output polarities are parameters.
- Adds direction, load, clear, hold, leading-zero blanking and a wrap flag.
- Sits directly under the board top; drives the DS_* display pins.

Parameters:
DIGITS, 4, number of BCD digits / display positions (1..8)
CNT_DIV, 50000000, CLK cycles per count step (>=1)
SCAN_DIV, 50000, CLK cycles each digit is enabled (>=1)
EN_ACTIVE_LOW, 1, 1 = DS_EN active-low, 0 = active-high
SEG_ACTIVE_LOW, 0, 1 = DS_A..DS_G, DS_DP active-low
BLANK_LZ, 1, 1 = blank leading zero digits

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
EN  in  1  count enable; prescaler holds when low
UP  in  1  1 = count up, 0 = count down
CLR  in  1  synchronous clear of value and prescaler
LOAD  in  1  synchronous load of LOAD_VAL
LOAD_VAL  in  4*DIGITS  BCD value to load; nibble 0 = least significant
VALUE  out  4*DIGITS  current BCD count
WRAP  out  1  one-cycle pulse on wrap (up: max->0, down: 0->max)
DS_EN  out  DIGITS  digit enables; bit 0 = least significant digit
DS_A..DS_G  out  1 each  segments a..g
DS_DP  out  1  decimal point

Behaviour:
- Reset (RST_N low, asynchronous):
  - VALUE=0, prescaler=0, scan index=0, scan divider=0, WRAP=0.
  - DS_EN all inactive; segments and DP off, at the configured polarity.
- Prescaler:
  - Counts 0..CNT_DIV-1 while EN=1; holds while EN=0.
  - tick=1 in the cycle where prescaler==CNT_DIV-1 and EN=1; the prescaler then returns to 0.
- Priority per cycle: CLR > LOAD > tick.
  - CLR: VALUE=0, prescaler=0, no WRAP.
  - LOAD: VALUE=LOAD_VAL, with any nibble >9 clamped to 9; prescaler=0; no WRAP.
- Tick, UP=1: BCD increment. Digit 9->0 carries into the next digit. All-9s -> all-0s asserts WRAP for exactly that following cycle.
- Tick, UP=0: BCD decrement. Digit 0->9 borrows. All-0s -> all-9s asserts WRAP.
- VALUE is registered; it updates one cycle after the tick/CLR/LOAD cycle.
- UP may change at any time; it takes effect on the next tick.
- Scan:
  - Scan divider runs 0..SCAN_DIV-1 continuously, independent of EN.
  - On wrap, scan index advances 0,1,..,DIGITS-1,0.
- Display outputs:
  - Registered. DS_EN, segments and DP for slot k change in the same cycle, one cycle after the index changes.
  - Exactly one DS_EN bit is active at any time after the first post-reset cycle.
- Decode, active-high sense before polarity:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
- Blanking: with BLANK_LZ=1, digit k>0 is blanked (all segments off) if it and every higher digit are 0. Digit 0 is never blanked.
- DS_DP is lit only on digit 0, and only while UP=0 (down-count indicator).
- Reset mid-count or mid-scan returns immediately to the reset state. The first post-reset display cycle shows digit 0.

Test Plan:
1. DIGITS=4, CNT_DIV=4. Reset, then EN=1, UP=1 for 40 cycles -> VALUE steps every 4 cycles: 0000, 0001, .., 0010 after 40 cycles. BCD carry 0009->0010 verified.
2. LOAD with LOAD_VAL=16'h9998, then count up 2 ticks -> VALUE 9999, then 0000. WRAP is high for exactly 1 cycle at the 0000 transition.
3. LOAD 16'h0000, UP=0, one tick -> VALUE 9999 and WRAP pulse. LOAD 16'h00AF -> VALUE 0099 (clamp).
4. Simultaneous CLR, LOAD and tick -> VALUE 0000, no WRAP. EN=0 for 20 cycles -> VALUE and prescaler frozen.
5. SCAN_DIV=2, VALUE=0070, EN_ACTIVE_LOW=1 -> DS_EN sequence 1110, 1101, 1011, 0111, 2 cycles each.
   - Segments: digit0 "0" = abcdef; digit1 "7" = abc; digits 2,3 blank.
   - DP lit on digit 0 only when UP=0.
6. Assert RST_N low mid-scan and mid-prescale -> outputs reset immediately, without waiting for a CLK edge. After release, DS_EN=1110 in the first cycle.

Source files
------------

// File: rtl/bcd_counter_scan_display.sv
// Parametrised BCD up/down counter with a time-multiplexed 7-segment driver.
// The count and the display scan run from independent CLK dividers.
module bcd_counter_scan_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CNT_DIV        = 50000000,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          EN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          BLANK_LZ       = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   VALUE,
    output logic                  WRAP,
    output logic [DIGITS-1:0]     DS_EN,
    output logic                  DS_A,
    output logic                  DS_B,
    output logic                  DS_C,
    output logic                  DS_D,
    output logic                  DS_E,
    output logic                  DS_F,
    output logic                  DS_G,
    output logic                  DS_DP
);

    localparam int unsigned VW    = 4 * DIGITS;
    localparam int unsigned PRE_W = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int unsigned SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CNT_DIV - 1);
    localparam logic [SCN_W-1:0] SCN_MAX = SCN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]  r_pre;
    logic [VW-1:0]     r_value;
    logic              r_wrap;
    logic [SCN_W-1:0]  r_scan_div;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0] r_ds_en;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_tick;
    logic [VW-1:0]     w_inc;
    logic [VW-1:0]     w_dec;
    logic [VW-1:0]     w_load;
    logic              w_carry_out;
    logic              w_borrow_out;
    logic [VW-1:0]     w_value_nxt;
    logic              w_wrap_nxt;
    logic              w_scan_last;
    logic [3:0]        w_digit;
    logic              w_blank;
    logic [DIGITS-1:0] w_en_oh;

    // Segment pattern {a,b,c,d,e,f,g}, active-high
    function automatic logic [6:0] decode7(input logic [3:0] d);
        case (d)
            4'd0:    decode7 = 7'b1111110;
            4'd1:    decode7 = 7'b0110000;
            4'd2:    decode7 = 7'b1101101;
            4'd3:    decode7 = 7'b1111001;
            4'd4:    decode7 = 7'b0110011;
            4'd5:    decode7 = 7'b1011011;
            4'd6:    decode7 = 7'b1011111;
            4'd7:    decode7 = 7'b1110000;
            4'd8:    decode7 = 7'b1111111;
            4'd9:    decode7 = 7'b1111011;
            default: decode7 = 7'b0000000;
        endcase
    endfunction

    assign w_tick      = EN && (r_pre == PRE_MAX);
    assign w_scan_last = (r_scan_div == SCN_MAX);

    // Ripple BCD increment/decrement, and clamped load value
    always_comb begin : bcd_arith
        logic [3:0] v_d;
        logic [3:0] v_l;
        logic       v_carry;
        logic       v_borrow;
        w_inc    = r_value;
        w_dec    = r_value;
        w_load   = '0;
        v_carry  = 1'b1;
        v_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            v_d = r_value[4*i +: 4];
            v_l = LOAD_VAL[4*i +: 4];
            w_load[4*i +: 4] = (v_l > 4'd9) ? 4'd9 : v_l;
            if (v_carry) begin
                if (v_d >= 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = v_d + 4'd1;
                    v_carry = 1'b0;
                end
            end
            if (v_borrow) begin
                if (v_d == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = v_d - 4'd1;
                    v_borrow = 1'b0;
                end
            end
        end
        w_carry_out  = v_carry;
        w_borrow_out = v_borrow;
    end

    always_comb begin
        w_value_nxt = r_value;
        w_wrap_nxt  = 1'b0;
        if (CLR) begin
            w_value_nxt = '0;
        end else if (LOAD) begin
            w_value_nxt = w_load;
        end else if (w_tick) begin
            w_value_nxt = UP ? w_inc : w_dec;
            w_wrap_nxt  = UP ? w_carry_out : w_borrow_out;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pre   <= '0;
            r_value <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_value <= w_value_nxt;
            r_wrap  <= w_wrap_nxt;
            if (CLR || LOAD) begin
                r_pre <= '0;
            end else if (EN) begin
                r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            end
        end
    end

    // Scan timebase runs regardless of EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_scan_div <= '0;
            r_idx      <= '0;
        end else begin
            r_scan_div <= w_scan_last ? '0 : r_scan_div + SCN_W'(1);
            if (w_scan_last) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Select the scanned digit; blank it if it and all higher digits are zero
    always_comb begin : digit_sel
        logic v_zero;
        w_digit = '0;
        w_blank = 1'b0;
        w_en_oh = '0;
        v_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_zero = v_zero && (r_value[4*i +: 4] == 4'd0);
            if (IDX_W'(i) == r_idx) begin
                w_digit    = r_value[4*i +: 4];
                w_blank    = BLANK_LZ && (i != 0) && v_zero;
                w_en_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ds_en <= {DIGITS{EN_ACTIVE_LOW}};
            r_seg   <= {7{SEG_ACTIVE_LOW}};
            r_dp    <= SEG_ACTIVE_LOW;
        end else begin
            r_ds_en <= w_en_oh ^ {DIGITS{EN_ACTIVE_LOW}};
            r_seg   <= (w_blank ? 7'b0000000 : decode7(w_digit)) ^ {7{SEG_ACTIVE_LOW}};
            r_dp    <= ((r_idx == '0) && !UP) ^ SEG_ACTIVE_LOW;
        end
    end

    assign VALUE = r_value;
    assign WRAP  = r_wrap;
    assign DS_EN = r_ds_en;
    assign DS_A  = r_seg[6];
    assign DS_B  = r_seg[5];
    assign DS_C  = r_seg[4];
    assign DS_D  = r_seg[3];
    assign DS_E  = r_seg[2];
    assign DS_F  = r_seg[1];
    assign DS_G  = r_seg[0];
    assign DS_DP = r_dp;

endmodule

// File: tb/tb_bcd_counter_scan_display.sv
// Scoreboard bench for bcd_counter_scan_display: 4 digits, fast count and scan.
module tb_bcd_counter_scan_display;

    localparam int unsigned DIGITS = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic        UP;
    logic        CLR;
    logic        LOAD;
    logic [15:0] LOAD_VAL;
    logic [15:0] VALUE;
    logic        WRAP;
    logic [3:0]  DS_EN;
    logic        DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G, DS_DP;
    logic [7:0]  seg8;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    bcd_counter_scan_display #(
        .DIGITS(DIGITS), .CNT_DIV(4), .SCAN_DIV(2),
        .EN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .VALUE(VALUE), .WRAP(WRAP), .DS_EN(DS_EN),
        .DS_A(DS_A), .DS_B(DS_B), .DS_C(DS_C), .DS_D(DS_D), .DS_E(DS_E),
        .DS_F(DS_F), .DS_G(DS_G), .DS_DP(DS_DP)
    );

    assign seg8 = {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G, DS_DP};

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    function automatic logic [15:0] bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Align to the first slot-0 sample, then walk 8 cycles of the 0070 display
    task automatic scan_pass(input logic dp0);
        logic [3:0] en_exp [4];
        logic [7:0] seg_exp[4];
        logic [3:0] prev;
        int found;
        en_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{{7'b1111110, dp0}, 8'b11100000, 8'b00000000, 8'b00000000};
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            prev = DS_EN;
            @(negedge CLK);
            if (prev != 4'b1110 && DS_EN == 4'b1110) found = 1;
        end
        check("scan_sync", 32'(found), 32'd1);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge CLK);
            push_exp(32'(en_exp[j/2]));
            check_pop("scan_ds_en", 32'(DS_EN));
            push_exp(32'(seg_exp[j/2]));
            check_pop("scan_seg_dp", 32'(seg8));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; EN = 1'b0; UP = 1'b1; CLR = 1'b0; LOAD = 1'b0; LOAD_VAL = '0;
        repeat (3) @(negedge CLK);
        push_exp(32'h0);  check_pop("rst_value", 32'(VALUE));
        push_exp(32'h0);  check_pop("rst_wrap", 32'(WRAP));
        push_exp(32'hF);  check_pop("rst_ds_en", 32'(DS_EN));
        push_exp(32'h0);  check_pop("rst_seg", 32'(seg8));

        // Count up with carry 0009 -> 0010
        RST_N = 1'b1; EN = 1'b1; UP = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push_exp(32'(bcd(k)));
            repeat (4) @(negedge CLK);
            check_pop("count_up", 32'(VALUE));
        end

        // Load 9998, two ticks up, single-cycle wrap
        LOAD = 1'b1; LOAD_VAL = 16'h9998;
        push_exp(32'h9998);
        @(negedge CLK); LOAD = 1'b0;
        check_pop("load_9998", 32'(VALUE));
        push_exp(32'h9999);
        repeat (4) @(negedge CLK);
        check_pop("tick_9999", 32'(VALUE));
        push_exp(32'h0); check_pop("no_wrap_9999", 32'(WRAP));
        for (int i = 1; i <= 4; i++) begin
            push_exp(32'(i == 4));
            @(negedge CLK);
            check_pop("wrap_up", 32'(WRAP));
        end
        push_exp(32'h0); check_pop("wrap_up_value", 32'(VALUE));
        push_exp(32'h0);
        @(negedge CLK);
        check_pop("wrap_one_cycle", 32'(WRAP));

        // Down wrap 0000 -> 9999, then clamp on load
        UP = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0000;
        push_exp(32'h0);
        @(negedge CLK); LOAD = 1'b0;
        check_pop("load_0000", 32'(VALUE));
        push_exp(32'h9999); push_exp(32'h1);
        repeat (4) @(negedge CLK);
        check_pop("down_wrap_value", 32'(VALUE));
        check_pop("down_wrap_pulse", 32'(WRAP));
        LOAD = 1'b1; LOAD_VAL = 16'h00AF;
        push_exp(32'h0099);
        @(negedge CLK); LOAD = 1'b0;
        check_pop("load_clamp", 32'(VALUE));

        // CLR beats LOAD beats tick
        push_exp(32'h0099);
        repeat (3) @(negedge CLK);
        check_pop("pre_at_max", 32'(VALUE));
        CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h9999;
        push_exp(32'h0); push_exp(32'h0);
        @(negedge CLK); CLR = 1'b0; LOAD = 1'b0;
        check_pop("clr_priority", 32'(VALUE));
        check_pop("clr_no_wrap", 32'(WRAP));

        // EN low freezes value and prescaler mid-count
        UP = 1'b1;
        repeat (2) @(negedge CLK);
        EN = 1'b0;
        push_exp(32'h0);
        repeat (20) @(negedge CLK);
        check_pop("en_hold_value", 32'(VALUE));
        EN = 1'b1;
        push_exp(32'h0);
        @(negedge CLK);
        check_pop("en_resume_3", 32'(VALUE));
        push_exp(32'h0001);
        @(negedge CLK);
        check_pop("en_resume_tick", 32'(VALUE));

        // Scan of 0070 with blanking, DP off then on
        EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0070;
        push_exp(32'h0070);
        @(negedge CLK); LOAD = 1'b0;
        check_pop("load_0070", 32'(VALUE));
        scan_pass(1'b0);
        UP = 1'b0;
        @(negedge CLK);
        scan_pass(1'b1);

        // Asynchronous reset mid-prescale and mid-scan
        UP = 1'b1; EN = 1'b1;
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        push_exp(32'h0);  check_pop("async_value", 32'(VALUE));
        push_exp(32'h0);  check_pop("async_wrap", 32'(WRAP));
        push_exp(32'hF);  check_pop("async_ds_en", 32'(DS_EN));
        push_exp(32'h0);  check_pop("async_seg", 32'(seg8));
        @(negedge CLK);
        RST_N = 1'b1;
        push_exp(32'hE); push_exp(32'hFC);
        @(negedge CLK);
        check_pop("post_rst_ds_en", 32'(DS_EN));
        check_pop("post_rst_seg", 32'(seg8));
        push_exp(32'h0);
        repeat (2) @(negedge CLK);
        check_pop("post_rst_pre", 32'(VALUE));
        push_exp(32'h0001);
        @(negedge CLK);
        check_pop("post_rst_tick", 32'(VALUE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
